// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared stall encodings, redirect constants and sequencer states
package pipeline_ctrl_pkg;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_IF = 6'b000011;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
  localparam logic [31:0] ERET_CODE = 32'h0000_000e;
  typedef enum logic [1:0] {ST_RUN, ST_EXC_WAIT, ST_FLUSH, ST_REFILL} state_t;
  function automatic logic [5:0] req_stall(input logic s_if, input logic s_id, input logic s_ex, input logic s_mem);
    return s_mem ? STALL_MEM : s_ex ? STALL_EX : s_id ? STALL_ID : s_if ? STALL_IF : '0;
  endfunction
endpackage

// File: rtl/pipeline_ctrl_perf.sv
// pipeline_ctrl_perf: wrapping stall-cycle counter and saturating accepted-exception counter
module pipeline_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush_start,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(stall_pc);
      flush_count <= (flush_start && flush_count != 16'hFFFF) ? flush_count + 16'd1 : flush_count;
    end
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges stage stall requests and sequences precise exceptions/ERET flushes
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);
  state_t state, next;
  logic [31:0] exc_type, exc_epc;
  logic pending, accept;
  always_comb begin
    pending = excepttype_i != '0;
    accept = !rst && (state == ST_RUN || state == ST_EXC_WAIT) && pending && !stallreq_from_mem;
    next = state == ST_FLUSH ? ST_REFILL : state == ST_REFILL ? ST_RUN :
           accept ? ST_FLUSH : pending ? ST_EXC_WAIT : ST_RUN;
    // REFILL ignores excepttype_i while CP0 settles, so only the request encoding applies there
    stall = (rst || state == ST_FLUSH) ? '0 :
            (state != ST_REFILL && pending) ? STALL_MEM :
            req_stall(stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      exc_type <= '0;
      exc_epc <= '0;
    end else begin
      state <= next;
      if (accept) begin
        exc_type <= excepttype_i;
        exc_epc <= cp0_epc_i;
      end
    end
  end
  assign flush = state == ST_FLUSH;
  assign new_pc = flush ? (exc_type == ERET_CODE ? exc_epc : EXC_VECTOR) : '0;
  pipeline_ctrl_perf u_perf (
    .clk(clk),
    .rst(rst),
    .stall_pc(stall[0]),
    .flush_start(accept),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );
endmodule
